peak_track_mc: RTL and testbench

Multi-channel, run-time-configurable successor to the single-channel frame peak detector. Tracks per-lane extreme values over a frame of programmable length on NUM_CH parallel sample lanes, in one of three modes (|x| max, signed max, signed min). It sits after the ADC/decimation front end and hands one result set per frame to the control/readout logic over a valid/ready handshake.

---
 rtl/peak_pkg.sv | 41 ++++
 rtl/peak_lane.sv | 57 +++++
 rtl/peak_track_mc.sv | 120 ++++++++++++
 tb/tb_peak_track_mc.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types and helpers for the multi-channel frame peak tracker.
// Helpers take operands pre-extended to PK_W bits so that one definition serves any lane width.
package peak_pkg;

    localparam int unsigned PK_W = 64;

    typedef enum logic [1:0] {
        PK_ABS = 2'b00,
        PK_MAX = 2'b01,
        PK_MIN = 2'b10
    } pk_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pk_state_e;

    // The unused encoding 2'b11 behaves as abs.
    function automatic pk_mode_e decode_mode(input logic [1:0] raw);
        return (raw == 2'b11) ? PK_ABS : pk_mode_e'(raw);
    endfunction

    // x is sign-extended from the lane width; the most negative lane value maps to 2^(WIDTH-1),
    // which still fits the lane width when read as unsigned.
    function automatic logic [PK_W-1:0] abs_sat(input logic [PK_W-1:0] x);
        return x[PK_W-1] ? (~x + PK_W'(1)) : x;
    endfunction

    // Operands are zero-extended in abs mode and sign-extended otherwise.
    function automatic logic pk_update(input pk_mode_e mode, input logic tie_last,
                                       input logic [PK_W-1:0] v, input logic [PK_W-1:0] p);
        logic beats;
        case (mode)
            PK_MAX:  beats = $signed(v) > $signed(p);
            PK_MIN:  beats = $signed(v) < $signed(p);
            default: beats = v > p;
        endcase
        return beats || (tie_last && (v == p));
    endfunction

endpackage

// File: rtl/peak_lane.sv
// One sample lane: value selection, compare against the running peak, and peak/index registers.
module peak_lane
    import peak_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LW       = 10,
    parameter bit          TIE_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  pk_mode_e         mode,
    input  logic [WIDTH-1:0] x,
    input  logic [LW-1:0]    idx,
    output logic [WIDTH-1:0] peak_nxt,
    output logic [LW-1:0]    idx_nxt
);

    logic [WIDTH-1:0] peak_q;
    logic [LW-1:0]    idx_q;
    logic [WIDTH-1:0] v;
    logic [PK_W-1:0]  x_sext;
    logic [PK_W-1:0]  x_abs;
    logic [PK_W-1:0]  v_ext;
    logic [PK_W-1:0]  p_ext;
    logic             upd;

    always_comb begin
        x_sext = {{(PK_W-WIDTH){x[WIDTH-1]}}, x};
        x_abs  = abs_sat(x_sext);
        if (mode == PK_ABS) begin
            v     = x_abs[WIDTH-1:0];
            v_ext = x_abs;
            p_ext = {{(PK_W-WIDTH){1'b0}}, peak_q};
        end else begin
            v     = x;
            v_ext = x_sext;
            p_ext = {{(PK_W-WIDTH){peak_q[WIDTH-1]}}, peak_q};
        end
        // Index 0 always loads so a stale peak from an earlier frame never competes.
        upd      = en && (first || pk_update(mode, TIE_LAST, v_ext, p_ext));
        peak_nxt = upd ? v : peak_q;
        idx_nxt  = upd ? idx : idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
            idx_q  <= '0;
        end else begin
            peak_q <= peak_nxt;
            idx_q  <= idx_nxt;
        end
    end

endmodule

// File: rtl/peak_track_mc.sv
// Multi-channel frame peak tracker: frame FSM, sample counter and result handshake registers.
// Per-lane compare and peak storage lives in peak_lane.
module peak_track_mc
    import peak_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned MAX_LEN  = 1024,
    parameter bit          TIE_LAST = 1'b1,
    localparam int unsigned LW      = $clog2(MAX_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LW:0]             frame_len,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] sample_in,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] peak_out,
    output logic [NUM_CH*LW-1:0]    peak_idx,
    output logic                    overrun
);

    localparam logic [LW:0] LEN_MAX = (LW+1)'(MAX_LEN);

    pk_state_e    state_q;
    logic [LW:0]  len_q;
    pk_mode_e     mode_q;
    logic [LW-1:0] count_q;

    pk_mode_e     start_mode;
    pk_mode_e     cur_mode;
    logic [LW:0]  start_len;
    logic [LW:0]  cur_len;
    logic [LW-1:0] cur_idx;
    logic         samp_en;
    logic         first;
    logic         last;

    logic [NUM_CH*WIDTH-1:0] peak_nxt;
    logic [NUM_CH*LW-1:0]    idx_nxt;

    // A start-cycle sample already belongs to the new frame, so bypass the latched settings.
    always_comb begin
        start_mode = decode_mode(mode);
        start_len  = (frame_len == '0 || frame_len > LEN_MAX) ? LEN_MAX : frame_len;
        cur_mode   = start ? start_mode : mode_q;
        cur_len    = start ? start_len : len_q;
        cur_idx    = start ? '0 : count_q;
        samp_en    = in_valid && (start || state_q == RUN);
        first      = (cur_idx == '0);
        last       = samp_en && ({1'b0, cur_idx} == cur_len - (LW+1)'(1));
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        peak_lane #(
            .WIDTH    (WIDTH),
            .LW       (LW),
            .TIE_LAST (TIE_LAST)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (samp_en),
            .first    (first),
            .mode     (cur_mode),
            .x        (sample_in[k*WIDTH +: WIDTH]),
            .idx      (cur_idx),
            .peak_nxt (peak_nxt[k*WIDTH +: WIDTH]),
            .idx_nxt  (idx_nxt[k*LW +: LW])
        );
    end

    assign busy = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            mode_q    <= PK_ABS;
            count_q   <= '0;
            out_valid <= 1'b0;
            peak_out  <= '0;
            peak_idx  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (start) begin
                state_q <= RUN;
                len_q   <= start_len;
                mode_q  <= start_mode;
                count_q <= '0;
            end
            if (samp_en) begin
                if (last) begin
                    state_q <= IDLE;
                    count_q <= '0;
                end else begin
                    count_q <= cur_idx + LW'(1);
                end
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A pending unaccepted result wins; the newer one is dropped and flagged.
            if (last) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    peak_out  <= peak_nxt;
                    peak_idx  <= idx_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_peak_track_mc.sv
// Self-checking bench for peak_track_mc: two instances (last- and first-occurrence tie policy)
// share stimulus; expected results come from a frame-level arithmetic model.
module tb_peak_track_mc;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned MAX_LEN = 1024;
    localparam int unsigned LW      = 10;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [LW:0] frame_len;
    logic [1:0] mode;
    logic in_valid;
    logic out_ready;
    logic [NUM_CH*WIDTH-1:0] sample_in;

    logic busy_a, out_valid_a, overrun_a;
    logic [NUM_CH*WIDTH-1:0] peak_out_a;
    logic [NUM_CH*LW-1:0] peak_idx_a;
    logic busy_b, out_valid_b, overrun_b;
    logic [NUM_CH*WIDTH-1:0] peak_out_b;
    logic [NUM_CH*LW-1:0] peak_idx_b;

    int n_checks = 0;
    int n_fail = 0;
    int smp[NUM_CH][MAX_LEN];
    logic [NUM_CH*WIDTH-1:0] exp_pk_a, exp_pk_b;
    logic [NUM_CH*LW-1:0] exp_ix_a, exp_ix_b;
    bit early_valid;

    always #5 clk = ~clk;

    peak_track_mc #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .TIE_LAST(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .mode(mode),
        .in_valid(in_valid), .sample_in(sample_in), .busy(busy_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .peak_out(peak_out_a), .peak_idx(peak_idx_a), .overrun(overrun_a)
    );

    peak_track_mc #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .TIE_LAST(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .mode(mode),
        .in_valid(in_valid), .sample_in(sample_in), .busy(busy_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .peak_out(peak_out_b), .peak_idx(peak_idx_b), .overrun(overrun_b)
    );

    // Ranking key: the value itself for max/min, its magnitude for abs.
    function automatic int key_of(input int x, input int md);
        if (md == 1 || md == 2) return x;
        return (x < 0) ? -x : x;
    endfunction

    task automatic build_expect(input int n, input int md);
        for (int k = 0; k < NUM_CH; k++) begin
            int best_a, best_b, ix_a, ix_b, v;
            best_a = key_of(smp[k][0], md);
            best_b = best_a;
            ix_a = 0;
            ix_b = 0;
            for (int i = 1; i < n; i++) begin
                v = key_of(smp[k][i], md);
                if ((md == 2) ? (v <= best_a) : (v >= best_a)) begin best_a = v; ix_a = i; end
                if ((md == 2) ? (v < best_b) : (v > best_b)) begin best_b = v; ix_b = i; end
            end
            exp_pk_a[k*WIDTH +: WIDTH] = best_a[WIDTH-1:0];
            exp_pk_b[k*WIDTH +: WIDTH] = best_b[WIDTH-1:0];
            exp_ix_a[k*LW +: LW] = ix_a[LW-1:0];
            exp_ix_b[k*LW +: LW] = ix_b[LW-1:0];
        end
    endtask

    function automatic int rand_sample();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        if (r < 6) return int'($urandom_range(0, 6)) - 3;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic fill_random(input int n);
        for (int k = 0; k < NUM_CH; k++)
            for (int i = 0; i < n; i++) smp[k][i] = rand_sample();
    endtask

    task automatic put_sample(input int i);
        for (int k = 0; k < NUM_CH; k++) sample_in[k*WIDTH +: WIDTH] = WIDTH'(smp[k][i]);
    endtask

    // Drives one frame of n samples with random idle gaps; start sits on the first cycle, which
    // carries sample 0 when lead is set. Returns 1 time unit after the last sample's edge.
    task automatic drive_frame(input logic [LW:0] flen, input logic [1:0] md, input int n,
                               input bit lead, input bit ready_last);
        int i;
        bit ov0, fst;
        ov0 = out_valid_a;
        early_valid = 0;
        fst = 1;
        i = 0;
        while (i < n) begin
            if (!ov0 && (out_valid_a || out_valid_b)) early_valid = 1;
            start = fst;
            if (fst) begin frame_len = flen; mode = md; end
            if ((fst && !lead) || (!fst && $urandom_range(0, 3) == 0)) begin
                in_valid = 0;
                for (int k = 0; k < NUM_CH; k++)
                    sample_in[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
            end else begin
                in_valid = 1;
                put_sample(i);
                if (i == n - 1 && ready_last) out_ready = 1;
                i++;
            end
            fst = 0;
            @(posedge clk);
            #1;
            start = 0;
            out_ready = 0;
        end
        in_valid = 0;
        build_expect(n, (md == 2'd3) ? 0 : int'(md));
    endtask

    task automatic accept();
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy_a, out_valid_a, overrun_a, peak_out_a, peak_idx_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a got busy=%b ov=%b orun=%b pk=%h ix=%h want all 0",
                     busy_a, out_valid_a, overrun_a, peak_out_a, peak_idx_a);
        end
        n_checks++;
        if ({busy_b, out_valid_b, overrun_b, peak_out_b, peak_idx_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b got busy=%b ov=%b orun=%b pk=%h ix=%h want all 0",
                     busy_b, out_valid_b, overrun_b, peak_out_b, peak_idx_b);
        end
        rst = 0;
        in_valid = 1;
        repeat (4) begin
            sample_in = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        n_checks++;
        if ({busy_a, out_valid_a, busy_b, out_valid_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ignore got busy/ov a=%b%b b=%b%b want 0000",
                     busy_a, out_valid_a, busy_b, out_valid_b);
        end
    endtask

    task automatic test_abs_plan();
        int l0[8] = '{3, -7, 5, 7, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin smp[0][i] = l0[i]; smp[1][i] = 0; end
        drive_frame(11'd8, 2'd0, 8, 1, 0);
        n_checks++;
        if (early_valid || out_valid_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abs_latency got early=%b ov=%b busy=%b want 0 1 0",
                     early_valid, out_valid_a, busy_a);
        end
        n_checks++;
        if ({peak_out_a, peak_idx_a} !== {16'd0, 16'd7, 10'd7, 10'd3}) begin
            n_fail++;
            $display("FAIL abs_plan_a got pk=%h ix=%h want pk=00000007 ix=(7,3)",
                     peak_out_a, peak_idx_a);
        end
        n_checks++;
        if ({peak_out_b, peak_idx_b} !== {16'd0, 16'd7, 10'd0, 10'd1}) begin
            n_fail++;
            $display("FAIL abs_plan_b got pk=%h ix=%h want pk=00000007 ix=(0,1)",
                     peak_out_b, peak_idx_b);
        end
        accept();
        n_checks++;
        if (out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abs_accept got ov=%b want 0", out_valid_a);
        end
    endtask

    task automatic test_saturation();
        int s0[4] = '{100, -32768, -5, 32767};
        int s1[4] = '{-1, 1, -1, 1};
        int s2[3] = '{-5, -2, -9};
        for (int i = 0; i < 4; i++) begin smp[0][i] = s0[i]; smp[1][i] = s1[i]; end
        drive_frame(11'd4, 2'd0, 4, 1, 0);
        n_checks++;
        if (peak_out_a[15:0] !== 16'h8000 || peak_idx_a[9:0] !== 10'd1) begin
            n_fail++;
            $display("FAIL sat_abs got pk=%h ix=%0d want 8000 1", peak_out_a[15:0],
                     peak_idx_a[9:0]);
        end
        n_checks++;
        if ({peak_out_b, peak_idx_b} !== {exp_pk_b, exp_ix_b}) begin
            n_fail++;
            $display("FAIL sat_abs_b got pk=%h ix=%h want pk=%h ix=%h", peak_out_b, peak_idx_b,
                     exp_pk_b, exp_ix_b);
        end
        accept();
        for (int i = 0; i < 3; i++) begin smp[0][i] = s2[i]; smp[1][i] = s2[i]; end
        drive_frame(11'd3, 2'd1, 3, 1, 0);
        n_checks++;
        if ({peak_out_a, peak_idx_a} !== {16'hFFFE, 16'hFFFE, 10'd1, 10'd1}) begin
            n_fail++;
            $display("FAIL sat_max got pk=%h ix=%h want pk=fffefffe ix=(1,1)", peak_out_a,
                     peak_idx_a);
        end
        accept();
        drive_frame(11'd3, 2'd2, 3, 1, 0);
        n_checks++;
        if ({peak_out_b, peak_idx_b} !== {16'hFFF7, 16'hFFF7, 10'd2, 10'd2}) begin
            n_fail++;
            $display("FAIL sat_min got pk=%h ix=%h want pk=fff7fff7 ix=(2,2)", peak_out_b,
                     peak_idx_b);
        end
        accept();
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int n;
            logic [1:0] md;
            n = int'($urandom_range(1, 40));
            md = 2'($urandom_range(0, 3));
            fill_random(n);
            drive_frame(11'(n), md, n, 1'($urandom_range(0, 1)), 0);
            n_checks++;
            if ({early_valid, out_valid_a, peak_out_a, peak_idx_a} !==
                {1'b0, 1'b1, exp_pk_a, exp_ix_a}) begin
                n_fail++;
                $display("FAIL random_a[%0d] md=%0d n=%0d got early=%b ov=%b pk=%h ix=%h want pk=%h ix=%h",
                         f, md, n, early_valid, out_valid_a, peak_out_a, peak_idx_a,
                         exp_pk_a, exp_ix_a);
            end
            n_checks++;
            if ({out_valid_b, peak_out_b, peak_idx_b} !== {1'b1, exp_pk_b, exp_ix_b}) begin
                n_fail++;
                $display("FAIL random_b[%0d] md=%0d n=%0d got ov=%b pk=%h ix=%h want pk=%h ix=%h",
                         f, md, n, out_valid_b, peak_out_b, peak_idx_b, exp_pk_b, exp_ix_b);
            end
            accept();
        end
    endtask

    task automatic test_handshake();
        logic [NUM_CH*WIDTH-1:0] e1_pk_a;
        logic [NUM_CH*LW-1:0] e1_ix_b;
        fill_random(4);
        drive_frame(11'd4, 2'd0, 4, 1, 0);
        e1_pk_a = exp_pk_a;
        e1_ix_b = exp_ix_b;
        n_checks++;
        if ({out_valid_a, overrun_a, peak_out_a} !== {1'b1, 1'b0, exp_pk_a}) begin
            n_fail++;
            $display("FAIL hs_first got ov=%b orun=%b pk=%h want 1 0 %h", out_valid_a,
                     overrun_a, peak_out_a, exp_pk_a);
        end
        fill_random(4);
        drive_frame(11'd4, 2'd1, 4, 1, 0);
        n_checks++;
        if ({out_valid_a, overrun_a, peak_out_a} !== {1'b1, 1'b1, e1_pk_a}) begin
            n_fail++;
            $display("FAIL hs_overrun_a got ov=%b orun=%b pk=%h want 1 1 %h", out_valid_a,
                     overrun_a, peak_out_a, e1_pk_a);
        end
        n_checks++;
        if ({overrun_b, peak_idx_b} !== {1'b1, e1_ix_b}) begin
            n_fail++;
            $display("FAIL hs_overrun_b got orun=%b ix=%h want 1 %h", overrun_b, peak_idx_b,
                     e1_ix_b);
        end
        accept();
        n_checks++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_drop got ov a=%b b=%b want 0 0", out_valid_a, out_valid_b);
        end
        fill_random(4);
        drive_frame(11'd4, 2'd2, 4, 1, 0);
        fill_random(5);
        drive_frame(11'd5, 2'd0, 5, 0, 1);
        n_checks++;
        if ({out_valid_a, peak_out_a, peak_idx_a} !== {1'b1, exp_pk_a, exp_ix_a}) begin
            n_fail++;
            $display("FAIL hs_accept_and_load got ov=%b pk=%h ix=%h want 1 %h %h", out_valid_a,
                     peak_out_a, peak_idx_a, exp_pk_a, exp_ix_a);
        end
        accept();
    endtask

    task automatic test_restart();
        start = 1;
        frame_len = 11'd16;
        mode = 2'd0;
        in_valid = 1;
        sample_in = {NUM_CH{16'h8000}};
        @(posedge clk);
        #1;
        start = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_busy got busy=%b ov=%b want 1 0", busy_a, out_valid_a);
        end
        for (int k = 0; k < NUM_CH; k++)
            for (int i = 0; i < 16; i++) smp[k][i] = int'($urandom_range(0, 20)) - 10;
        drive_frame(11'd16, 2'd0, 16, 1, 0);
        n_checks++;
        if ({early_valid, out_valid_a, peak_out_a, peak_idx_a} !==
            {1'b0, 1'b1, exp_pk_a, exp_ix_a}) begin
            n_fail++;
            $display("FAIL restart_a got early=%b ov=%b pk=%h ix=%h want 0 1 %h %h", early_valid,
                     out_valid_a, peak_out_a, peak_idx_a, exp_pk_a, exp_ix_a);
        end
        n_checks++;
        if ({peak_out_b, peak_idx_b} !== {exp_pk_b, exp_ix_b}) begin
            n_fail++;
            $display("FAIL restart_b got pk=%h ix=%h want %h %h", peak_out_b, peak_idx_b,
                     exp_pk_b, exp_ix_b);
        end
        accept();
    endtask

    task automatic test_boundaries();
        logic [LW:0] lens[2] = '{11'd0, 11'd2000};
        for (int j = 0; j < 2; j++) begin
            fill_random(MAX_LEN);
            drive_frame(lens[j], 2'($urandom_range(0, 3)), MAX_LEN, 1, 0);
            n_checks++;
            if ({early_valid, out_valid_a, peak_out_a, peak_idx_a, peak_idx_b} !==
                {1'b0, 1'b1, exp_pk_a, exp_ix_a, exp_ix_b}) begin
                n_fail++;
                $display("FAIL maxlen[%0d] got early=%b ov=%b pk=%h ix=%h/%h want %h %h/%h",
                         lens[j], early_valid, out_valid_a, peak_out_a, peak_idx_a, peak_idx_b,
                         exp_pk_a, exp_ix_a, exp_ix_b);
            end
            accept();
        end
        for (int f = 0; f < 3; f++) begin
            fill_random(1);
            drive_frame(11'd1, 2'($urandom_range(0, 3)), 1, 1, 1);
            n_checks++;
            if ({out_valid_a, peak_out_a, peak_idx_a, peak_idx_b} !==
                {1'b1, exp_pk_a, {(NUM_CH*LW){1'b0}}, {(NUM_CH*LW){1'b0}}}) begin
                n_fail++;
                $display("FAIL len1[%0d] got ov=%b pk=%h ix=%h/%h want 1 %h 0/0", f,
                         out_valid_a, peak_out_a, peak_idx_a, peak_idx_b, exp_pk_a);
            end
        end
        accept();
        for (int i = 0; i < 4; i++) begin smp[0][i] = 5; smp[1][i] = -3; end
        drive_frame(11'd4, 2'd1, 4, 1, 0);
        n_checks++;
        if ({peak_idx_a, peak_idx_b} !== {10'd3, 10'd3, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL tie_policy got ix a=%h b=%h want a=(3,3) b=(0,0)", peak_idx_a,
                     peak_idx_b);
        end
        accept();
    endtask

    task automatic test_rst_mid();
        start = 1;
        frame_len = 11'd10;
        mode = 2'd1;
        in_valid = 1;
        sample_in = {NUM_CH{16'd1234}};
        @(posedge clk);
        #1;
        start = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        #1;
        n_checks++;
        if ({busy_a, out_valid_a, overrun_a, peak_out_a, peak_idx_a} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_a got busy=%b ov=%b orun=%b pk=%h ix=%h want all 0",
                     busy_a, out_valid_a, overrun_a, peak_out_a, peak_idx_a);
        end
        #1;
        rst = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        n_checks++;
        if ({busy_a, out_valid_a, busy_b, out_valid_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_no_start got busy/ov a=%b%b b=%b%b want 0000", busy_a,
                     out_valid_a, busy_b, out_valid_b);
        end
        fill_random(3);
        drive_frame(11'd3, 2'd2, 3, 1, 0);
        n_checks++;
        if ({out_valid_b, peak_out_b, peak_idx_b} !== {1'b1, exp_pk_b, exp_ix_b}) begin
            n_fail++;
            $display("FAIL rst_recover got ov=%b pk=%h ix=%h want 1 %h %h", out_valid_b,
                     peak_out_b, peak_idx_b, exp_pk_b, exp_ix_b);
        end
        rst = 1;
        #1;
        n_checks++;
        if ({busy_b, out_valid_b, overrun_b, peak_out_b, peak_idx_b} !== '0) begin
            n_fail++;
            $display("FAIL rst_valid_b got busy=%b ov=%b orun=%b pk=%h ix=%h want all 0",
                     busy_b, out_valid_b, overrun_b, peak_out_b, peak_idx_b);
        end
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1;
        start = 0;
        in_valid = 0;
        out_ready = 0;
        frame_len = '0;
        mode = 2'd0;
        sample_in = '0;
        test_reset();
        test_abs_plan();
        test_saturation();
        test_random();
        test_handshake();
        test_restart();
        test_boundaries();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
